// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one frame-buffer command port between display, background and overlay engines
module fb_mem_arbiter #(
  parameter int ADDR_WIDTH = 31,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dp_valid,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  input  logic                  dp_rnw,
  input  logic                  dp_last,
  output logic                  dp_ready,
  input  logic                  bg_valid,
  input  logic [ADDR_WIDTH-1:0] bg_addr,
  input  logic                  bg_rnw,
  input  logic                  bg_last,
  output logic                  bg_ready,
  input  logic                  ol_valid,
  input  logic [ADDR_WIDTH-1:0] ol_addr,
  input  logic                  ol_rnw,
  input  logic                  ol_last,
  output logic                  ol_ready,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rnw,
  input  logic                  mem_ready,
  output logic [1:0]            grant,
  output logic                  timeout_pulse
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] grant_n;
  logic [BW-1:0] burst, burst_n;
  logic [TW-1:0] idle, idle_n;
  logic rr_next, rr_n, pulse_n;
  logic sel_valid, sel_last, accept;
  // route the granted engine's command fields; grant 0 selects nothing so IDLE outputs are zero
  always_comb begin
    sel_valid = grant == 2'd1 ? dp_valid : grant == 2'd2 ? bg_valid : grant == 2'd3 ? ol_valid : 1'b0;
    sel_last  = grant == 2'd1 ? dp_last  : grant == 2'd2 ? bg_last  : grant == 2'd3 ? ol_last  : 1'b0;
    mem_rnw   = grant == 2'd1 ? dp_rnw   : grant == 2'd2 ? bg_rnw   : grant == 2'd3 ? ol_rnw   : 1'b0;
    mem_addr  = grant == 2'd1 ? dp_addr  : grant == 2'd2 ? bg_addr  : grant == 2'd3 ? ol_addr  : '0;
  end
  assign mem_valid = sel_valid;
  assign accept    = sel_valid & mem_ready;
  assign dp_ready  = grant == 2'd1 && mem_ready;
  assign bg_ready  = grant == 2'd2 && mem_ready;
  assign ol_ready  = grant == 2'd3 && mem_ready;
  // arbitration in IDLE; burst/idle accounting and release conditions in GRANT
  always_comb begin
    state_n = state;
    grant_n = grant;
    burst_n = burst;
    idle_n  = idle;
    rr_n    = rr_next;
    pulse_n = 1'b0;
    if (state == IDLE) begin
      grant_n = dp_valid ? 2'd1 : (bg_valid && ol_valid) ? (rr_next ? 2'd3 : 2'd2) :
                bg_valid ? 2'd2 : ol_valid ? 2'd3 : 2'd0;
      state_n = grant_n != 2'd0 ? GRANT : IDLE;
      rr_n    = grant_n == 2'd2 ? 1'b1 : grant_n == 2'd3 ? 1'b0 : rr_next;
    end else begin
      burst_n = burst + BW'(accept);
      idle_n  = sel_valid ? '0 : idle + TW'(1);
      pulse_n = !sel_valid && idle == IDLE_LAST;
      if ((accept && (sel_last || burst_n == BURST_CAP)) || pulse_n) begin
        state_n = IDLE;
        grant_n = 2'd0;
        burst_n = '0;
        idle_n  = '0;
      end
    end
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 2'd0;
      burst         <= '0;
      idle          <= '0;
      rr_next       <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      burst         <= burst_n;
      idle          <= idle_n;
      rr_next       <= rr_n;
      timeout_pulse <= pulse_n;
    end
  end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: directed and randomized checks of fb_mem_arbiter against a cycle model
module tb_fb_mem_arbiter;
  localparam int AW = 31;
  localparam int MB = 16;
  localparam int TO = 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mem_ready = 1'b0;
  logic v[3], w[3], l[3];
  logic [AW-1:0] a[3];
  logic dp_ready, bg_ready, ol_ready, mem_valid, mem_rnw, timeout_pulse;
  logic [AW-1:0] mem_addr;
  logic [1:0] grant;
  int g, bc, ic, rr;
  bit p;
  int beat[3], blen[3], bursts[3];
  bit stall[3];
  int checks, errors, pulses, n;
  logic [1:0] prev_grant;
  logic [11:0] gseq;

  fb_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .dp_valid(v[0]), .dp_addr(a[0]), .dp_rnw(w[0]), .dp_last(l[0]), .dp_ready(dp_ready),
    .bg_valid(v[1]), .bg_addr(a[1]), .bg_rnw(w[1]), .bg_last(l[1]), .bg_ready(bg_ready),
    .ol_valid(v[2]), .ol_addr(a[2]), .ol_rnw(w[2]), .ol_last(l[2]), .ol_ready(ol_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_ready(mem_ready),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 3; i++) begin
      v[i] = bursts[i] > 0 && !stall[i];
      l[i] = blen[i] > 0 && beat[i] == blen[i] - 1;
    end
  endtask

  task automatic req(input int i, input int nb, input int len);
    bursts[i] = nb;
    blen[i] = len;
    beat[i] = 0;
    a[i] = AW'($urandom);
    w[i] = 1'($urandom);
    refresh();
  endtask

  // one clock: check outputs mid-cycle, then advance model and requesters past the edge
  task automatic tick();
    bit acc[3];
    bit sv, rel;
    refresh();
    @(negedge clock);
    sv = g != 0 ? v[g-1] : 1'b0;
    chk("grant", grant, g);
    chk("mem_valid", mem_valid, sv);
    chk("mem_addr", mem_addr, g != 0 ? a[g-1] : '0);
    chk("mem_rnw", mem_rnw, g != 0 ? w[g-1] : 1'b0);
    chk("ready", {dp_ready, bg_ready, ol_ready}, {g == 1 && mem_ready, g == 2 && mem_ready, g == 3 && mem_ready});
    chk("timeout_pulse", timeout_pulse, p);
    if (grant !== prev_grant && grant != 2'd0) gseq = {gseq[9:0], grant};
    prev_grant = grant;
    pulses += int'(timeout_pulse);
    @(posedge clock);
    #1;
    if (reset) begin
      g = 0; bc = 0; ic = 0; rr = 0; p = 0;
      for (int i = 0; i < 3; i++) begin
        bursts[i] = 0; beat[i] = 0; stall[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) acc[i] = g == i + 1 && v[i] && mem_ready;
      p = 0;
      if (g == 0) begin
        if (v[0]) g = 1;
        else if (v[1] && v[2]) g = rr ? 3 : 2;
        else if (v[1]) g = 2;
        else if (v[2]) g = 3;
        if (g == 2) rr = 1;
        else if (g == 3) rr = 0;
      end else begin
        rel = 0;
        if (sv && mem_ready) begin
          bc++;
          rel = l[g-1] || bc == MB;
        end
        if (sv) ic = 0;
        else begin
          ic++;
          if (ic == TO) begin
            rel = 1;
            p = 1;
          end
        end
        if (rel) begin
          g = 0; bc = 0; ic = 0;
        end
      end
      for (int i = 0; i < 3; i++) if (acc[i]) begin
        a[i] = a[i] + 1'b1;
        w[i] = 1'($urandom);
        if (l[i]) begin
          bursts[i]--;
          beat[i] = 0;
        end else beat[i]++;
      end
    end
    refresh();
  endtask

  task automatic wait_grant(input logic [1:0] gv);
    for (int k = 0; k < 300 && grant !== gv; k++) tick();
    chk("wait_grant", grant, gv);
  endtask

  task automatic count_grant(input logic [1:0] gv);
    n = 0;
    while (grant === gv && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      bursts[i] = 0; blen[i] = 0; beat[i] = 0; stall[i] = 0; a[i] = '0; w[i] = 1'b0;
    end
    prev_grant = 2'd0;
    gseq = '0;
    refresh();
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("idle_grant", grant, 2'd0);
    chk("idle_pulses", pulses, 0);

    mem_ready = 1'b1;
    gseq = '0;
    req(0, 1, 4); req(1, 1, 3); req(2, 1, 3);
    wait_grant(2'd1);
    count_grant(2'd1);
    chk("dp_burst_cycles", n, 4);
    repeat (12) tick();
    chk("priority_order", gseq[5:0], {2'd1, 2'd2, 2'd3});

    gseq = '0;
    req(1, 3, 2); req(2, 3, 2);
    repeat (25) tick();
    chk("alternation", gseq, {2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3});

    gseq = '0;
    req(1, 1, 20); req(2, 1, 2);
    wait_grant(2'd2);
    count_grant(2'd2);
    chk("burst_cap", n, MB);
    repeat (10) tick();
    chk("cap_order", gseq[5:0], {2'd2, 2'd3, 2'd2});
    chk("bg_done", bursts[1], 0);

    req(2, 1, 3);
    wait_grant(2'd3);
    stall[2] = 1;
    req(0, 1, 2);
    pulses = 0;
    count_grant(2'd3);
    chk("timeout_cycles", n, TO);
    chk("timeout_pulse_now", timeout_pulse, 1'b1);
    tick();
    chk("dp_after_timeout", grant, 2'd1);
    chk("pulse_count", pulses, 1);
    stall[2] = 0;
    repeat (20) tick();

    req(0, 1, 4);
    wait_grant(2'd1);
    mem_ready = 1'b0;
    pulses = 0;
    repeat (100) tick();
    chk("stall_grant", grant, 2'd1);
    chk("stall_pulses", pulses, 0);
    chk("stall_ready", dp_ready, 1'b0);
    mem_ready = 1'b1;
    count_grant(2'd1);
    chk("stall_burst_cycles", n, 4);
    repeat (3) tick();

    req(0, 1, 8);
    wait_grant(2'd1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("reset_grant", grant, 2'd0);
    chk("reset_valid", mem_valid, 1'b0);
    reset = 1'b0;
    tick();

    for (int c = 0; c < 4000; c++) begin
      mem_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 999) == 0;
      for (int i = 0; i < 3; i++) begin
        if (bursts[i] == 0 && $urandom_range(0, 9) == 0) req(i, $urandom_range(1, 3), $urandom_range(1, 20));
        if ($urandom_range(0, 19) == 0) stall[i] = !stall[i];
      end
      tick();
    end
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
